// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and types for the fetch controller: RV32I opcodes, funct3 codes,
// pcmux encodings and the controller state enum.
package fetch_ctrl_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int CNT_W = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] PCMUX_JALR = 2'd0;
    localparam logic [1:0] PCMUX_JAL  = 2'd1;
    localparam logic [1:0] PCMUX_BR   = 2'd2;
    localparam logic [1:0] PCMUX_SEQ  = 2'd3;

    typedef enum logic [1:0] {FLUSH, RUN, HALT} state_t;

    // Legal RV32I opcodes that never redirect the fetch stream.
    function automatic logic is_plain_op(input logic [6:0] op);
        return (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_IMM) || (op == OP_OP) || (op == OP_FENCE);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch/issue/writeback bundle between imem, fetch_ctrl and execute. The imem fetch
// toggle is called fetch_new because "new" is a reserved word.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic [XLEN-1:0] idata;
    logic            fetch_new;
    logic [XLEN-1:0] pc;
    logic [1:0]      pcmux;
    logic [XLEN-1:0] rv1;
    logic [XLEN-1:0] imm;
    logic            in;
    logic            issue_valid;
    logic [XLEN-1:0] issue_instr;
    logic [XLEN-1:0] issue_pc;
    logic [XLEN-1:0] issue_rs1v;
    logic [XLEN-1:0] issue_rs2v;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    modport master (
        input  idata, fetch_new, pc, wb_en, wb_rd, wb_data,
        output pcmux, rv1, imm, in,
        output issue_valid, issue_instr, issue_pc, issue_rs1v, issue_rs2v
    );

    modport slave (
        output idata, fetch_new, pc, wb_en, wb_rd, wb_data,
        input  pcmux, rv1, imm, in,
        input  issue_valid, issue_instr, issue_pc, issue_rs1v, issue_rs2v
    );

endinterface

// File: rtl/fetch_ctrl_rf.sv
// 32x32 integer register file: two combinational read ports with same-cycle write
// bypass, one write port, asynchronous clear. x0 always reads as zero.
module fetch_ctrl_rf
    import fetch_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Writeback data in flight this cycle wins over the stored value.
    always_comb begin
        rs1_data = regs[rs1_addr];
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else if (wr_en && (wr_addr == rs1_addr)) begin
            rs1_data = wr_data;
        end
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else if (wr_en && (wr_addr == rs2_addr)) begin
            rs2_data = wr_data;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: decodes control transfers for imem in the same cycle,
// issues instructions with operands, halts on SYSTEM/illegal. Optional FETCH_CTRL_STATS_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    fetch_ctrl_if.master     bus,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] redir_cnt
);

    state_t          state;
    state_t          state_nxt;
    logic            new_q;
    logic            valid;
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rs1v;
    logic [XLEN-1:0] rs2v;
    logic [XLEN-1:0] i_imm;
    logic [XLEN-1:0] b_imm;
    logic [XLEN-1:0] j_imm;
    logic            is_jal;
    logic            is_jalr;
    logic            is_branch;
    logic            illegal;
    logic            br_taken;
    logic            redirect;
    logic [1:0]      pcmux;
    logic [XLEN-1:0] rv1;
    logic [XLEN-1:0] imm;
    logic            taken;
    logic            issue_valid;

    assign opcode = bus.idata[6:0];
    assign f3     = bus.idata[14:12];
    assign rs1    = bus.idata[19:15];
    assign rs2    = bus.idata[24:20];
    assign valid  = bus.fetch_new ^ new_q;

    assign i_imm = {{20{bus.idata[31]}}, bus.idata[31:20]};
    assign b_imm = {{19{bus.idata[31]}}, bus.idata[31], bus.idata[7],
                    bus.idata[30:25], bus.idata[11:8], 1'b0};
    assign j_imm = {{11{bus.idata[31]}}, bus.idata[31], bus.idata[19:12],
                    bus.idata[20], bus.idata[30:21], 1'b0};

    fetch_ctrl_rf u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1v),
        .rs2_data (rs2v),
        .wr_en    (bus.wb_en),
        .wr_addr  (bus.wb_rd),
        .wr_data  (bus.wb_data)
    );

    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR) && (f3 == F3_JALR);
    assign is_branch = (opcode == OP_BRANCH) && (f3 != 3'b010) && (f3 != 3'b011);
    assign illegal   = !(is_jal || is_jalr || is_branch || is_plain_op(opcode));

    always_comb begin
        case (f3)
            F3_BEQ:  br_taken = (rs1v == rs2v);
            F3_BNE:  br_taken = (rs1v != rs2v);
            F3_BLT:  br_taken = ($signed(rs1v) <  $signed(rs2v));
            F3_BGE:  br_taken = ($signed(rs1v) >= $signed(rs2v));
            F3_BLTU: br_taken = (rs1v <  rs2v);
            F3_BGEU: br_taken = (rs1v >= rs2v);
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FLUSH;
            new_q <= 1'b0;
        end else begin
            state <= state_nxt;
            new_q <= bus.fetch_new;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FLUSH:   state_nxt = RUN;
            RUN:     if (valid && illegal) state_nxt = HALT;
            HALT:    state_nxt = HALT;
            default: state_nxt = FLUSH;
        endcase
    end

    // Halting drives a zero-offset PC-relative jump so imem keeps refetching in place.
    always_comb begin
        pcmux       = PCMUX_SEQ;
        imm         = '0;
        rv1         = '0;
        taken       = 1'b0;
        issue_valid = 1'b0;
        halted      = 1'b0;
        redirect    = 1'b0;
        case (state)
            RUN: begin
                if (valid) begin
                    if (illegal) begin
                        halted = 1'b1;
                        pcmux  = PCMUX_JAL;
                    end else begin
                        issue_valid = 1'b1;
                        rv1         = rs1v;
                        if (is_jal) begin
                            pcmux    = PCMUX_JAL;
                            imm      = j_imm;
                            redirect = 1'b1;
                        end else if (is_jalr) begin
                            pcmux    = PCMUX_JALR;
                            imm      = i_imm;
                            redirect = 1'b1;
                        end else if (is_branch) begin
                            pcmux    = PCMUX_BR;
                            imm      = b_imm;
                            taken    = br_taken;
                            redirect = br_taken;
                        end
                    end
                end
            end
            HALT: begin
                halted = 1'b1;
                pcmux  = PCMUX_JAL;
            end
            default: ;
        endcase
    end

    assign bus.pcmux       = pcmux;
    assign bus.imm         = imm;
    assign bus.rv1         = rv1;
    assign bus.in          = taken;
    assign bus.issue_valid = issue_valid;
    assign bus.issue_instr = bus.idata;
    assign bus.issue_pc    = bus.pc - 32'd4;
    assign bus.issue_rs1v  = rs1v;
    assign bus.issue_rs2v  = rs2v;

`ifdef FETCH_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt <= '0;
            redir_cnt <= '0;
        end else begin
            if (issue_valid) instr_cnt <= instr_cnt + 1'b1;
            if (redirect)    redir_cnt <= redir_cnt + 1'b1;
        end
    end
`else
    assign instr_cnt = '0;
    assign redir_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed cases plus randomized instruction
// streams compared against an instruction-level reference model.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             halted;
    logic [CNT_W-1:0] instr_cnt;
    logic [CNT_W-1:0] redir_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .halted    (halted),
        .instr_cnt (instr_cnt),
        .redir_cnt (redir_cnt)
    );

    always #5 clk = ~clk;

    // Architectural view: register contents, last sampled fetch toggle, halt flag, counts.
    logic [31:0] m_regs [32];
    logic        m_prev_new;
    bit          m_halt;
    logic [31:0] m_instr;
    logic [31:0] m_redir;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] cntExp(input logic [31:0] v);
`ifdef FETCH_CTRL_STATS_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    function automatic logic [31:0] readModel(input logic [4:0] idx, input bit wen,
                                              input logic [4:0] wrd, input logic [31:0] wdata);
        if (idx == 5'd0) return 32'd0;
        if (wen && wrd == idx) return wdata;
        return m_regs[idx];
    endfunction

    function automatic bit plainLegal(input logic [6:0] op);
        return op inside {7'h37, 7'h17, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_prev_new = 1'b0;
        m_halt     = 1'b0;
        m_instr    = 32'd0;
        m_redir    = 32'd0;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.wb_en = 1'b0;
        #1;
        checkOutput("rst.pcmux", {30'd0, bus.pcmux}, 32'd3);
        checkOutput("rst.imm", bus.imm, 32'd0);
        checkOutput("rst.in", {31'd0, bus.in}, 32'd0);
        checkOutput("rst.rv1", bus.rv1, 32'd0);
        checkOutput("rst.issue_valid", {31'd0, bus.issue_valid}, 32'd0);
        checkOutput("rst.halted", {31'd0, halted}, 32'd0);
        checkOutput("rst.instr_cnt", instr_cnt, 32'd0);
        checkOutput("rst.redir_cnt", redir_cnt, 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("flush.issue_valid", {31'd0, bus.issue_valid}, 32'd0);
        checkOutput("flush.pcmux", {30'd0, bus.pcmux}, 32'd3);
        m_prev_new = bus.fetch_new;
    endtask

    // One cycle: drive after the rising edge, compare against the model at the falling edge.
    task automatic applyStimulus(input logic [31:0] instr, input bit tog, input logic [31:0] pc,
                                 input bit wen, input logic [4:0] wrd, input logic [31:0] wdata,
                                 input string tag);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] r1, r2, e_imm;
        logic [1:0]  e_pcmux;
        bit          e_in, e_iv, e_halted, e_redir, is_jalr, valid;
        int          v;
        @(posedge clk);
        #1;
        bus.idata     = instr;
        bus.fetch_new = tog ? ~bus.fetch_new : bus.fetch_new;
        bus.pc        = pc;
        bus.wb_en     = wen;
        bus.wb_rd     = wrd;
        bus.wb_data   = wdata;
        @(negedge clk);
        op = instr[6:0];
        f3 = instr[14:12];
        r1 = readModel(instr[19:15], wen, wrd, wdata);
        r2 = readModel(instr[24:20], wen, wrd, wdata);
        valid = (bus.fetch_new != m_prev_new);
        e_pcmux = 2'd3; e_imm = 32'd0; e_in = 0; e_iv = 0; e_redir = 0; is_jalr = 0;
        e_halted = m_halt;
        if (m_halt) begin
            e_pcmux = 2'd1;
        end else if (valid) begin
            if (op == 7'h6F) begin
                v = int'(instr[31]) * (1 << 20) + int'(instr[19:12]) * (1 << 12)
                  + int'(instr[20]) * (1 << 11) + int'(instr[30:21]) * 2;
                if (instr[31]) v -= (1 << 21);
                e_pcmux = 2'd1; e_imm = v; e_iv = 1; e_redir = 1;
            end else if (op == 7'h67 && f3 == 3'd0) begin
                v = int'(instr[31:20]);
                if (instr[31]) v -= 4096;
                e_pcmux = 2'd0; e_imm = v; e_iv = 1; e_redir = 1; is_jalr = 1;
            end else if (op == 7'h63 && f3 != 3'd2 && f3 != 3'd3) begin
                v = int'(instr[31]) * (1 << 12) + int'(instr[7]) * (1 << 11)
                  + int'(instr[30:25]) * (1 << 5) + int'(instr[11:8]) * 2;
                if (instr[31]) v -= (1 << 13);
                case (f3)
                    3'd0: e_in = (r1 == r2);
                    3'd1: e_in = (r1 != r2);
                    3'd4: e_in = (int'(r1) < int'(r2));
                    3'd5: e_in = (int'(r1) >= int'(r2));
                    3'd6: e_in = (r1 < r2);
                    default: e_in = (r1 >= r2);
                endcase
                e_pcmux = 2'd2; e_imm = v; e_iv = 1; e_redir = e_in;
            end else if (plainLegal(op)) begin
                e_iv = 1;
            end else begin
                e_halted = 1; e_pcmux = 2'd1;
            end
        end
        checkOutput({tag, ".pcmux"}, {30'd0, bus.pcmux}, {30'd0, e_pcmux});
        checkOutput({tag, ".imm"}, bus.imm, e_imm);
        checkOutput({tag, ".in"}, {31'd0, bus.in}, {31'd0, e_in});
        checkOutput({tag, ".issue_valid"}, {31'd0, bus.issue_valid}, {31'd0, e_iv});
        checkOutput({tag, ".halted"}, {31'd0, halted}, {31'd0, e_halted});
        checkOutput({tag, ".issue_instr"}, bus.issue_instr, instr);
        checkOutput({tag, ".issue_pc"}, bus.issue_pc, pc - 32'd4);
        checkOutput({tag, ".rs1v"}, bus.issue_rs1v, r1);
        checkOutput({tag, ".rs2v"}, bus.issue_rs2v, r2);
        if (is_jalr) checkOutput({tag, ".rv1"}, bus.rv1, r1);
        checkOutput({tag, ".instr_cnt"}, instr_cnt, cntExp(m_instr));
        checkOutput({tag, ".redir_cnt"}, redir_cnt, cntExp(m_redir));
        if (wen && wrd != 5'd0) m_regs[wrd] = wdata;
        m_prev_new = bus.fetch_new;
        if (e_iv) m_instr++;
        if (e_redir) m_redir++;
        if (e_halted) m_halt = 1;
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] r;
        logic [6:0]  plain [7];
        logic [2:0]  bf3 [6];
        int          k;
        plain = '{7'h37, 7'h17, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
        bf3   = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        r = $urandom();
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        k = $urandom_range(0, 9);
        if (k == 0) begin
            r[6:0] = 7'h6F;
        end else if (k == 1) begin
            r[6:0] = 7'h67; r[14:12] = 3'd0;
        end else if (k <= 4) begin
            r[6:0] = 7'h63; r[14:12] = bf3[$urandom_range(0, 5)];
        end else begin
            r[6:0] = plain[$urandom_range(0, 6)];
        end
        return r;
    endfunction

    initial begin
        bus.idata = 32'd0; bus.fetch_new = 1'b0; bus.pc = 32'd0;
        bus.wb_en = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
        modelReset();
        doReset();

        applyStimulus(32'h00100093, 1, 32'h4, 0, 5'd0, 32'd0, "addi");
        checkOutput("addi.valid_const", {31'd0, bus.issue_valid}, 32'd1);
        applyStimulus(32'h010000EF, 1, 32'h24, 0, 5'd0, 32'd0, "jal");
        checkOutput("jal.imm_const", bus.imm, 32'd16);
        checkOutput("jal.pc_const", bus.issue_pc, 32'h20);
        applyStimulus(32'h00000013, 0, 32'h28, 1, 5'd5, 32'd7, "wb_x5");
        applyStimulus(32'h00000013, 0, 32'h28, 1, 5'd6, 32'd7, "wb_x6");
        applyStimulus(32'hFE628CE3, 1, 32'h30, 0, 5'd0, 32'd0, "beq_eq");
        checkOutput("beq_eq.in_const", {31'd0, bus.in}, 32'd1);
        checkOutput("beq_eq.imm_const", bus.imm, 32'hFFFF_FFF8);
        applyStimulus(32'h00000013, 0, 32'h30, 1, 5'd6, 32'd8, "wb_x6b");
        applyStimulus(32'hFE628CE3, 1, 32'h34, 0, 5'd0, 32'd0, "beq_ne");
        checkOutput("beq_ne.in_const", {31'd0, bus.in}, 32'd0);
        applyStimulus(32'h00428067, 1, 32'h38, 1, 5'd5, 32'h100, "jalr_byp");
        checkOutput("jalr_byp.rv1_const", bus.rv1, 32'h100);
        applyStimulus(32'h00400067, 1, 32'h0, 1, 5'd0, 32'hDEAD, "jalr_x0w");
        applyStimulus(32'h00400067, 1, 32'h8, 0, 5'd0, 32'd0, "jalr_x0");
        checkOutput("jalr_x0.rv1_const", bus.rv1, 32'd0);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(randInstr(), 1'($urandom_range(0, 1)), $urandom(),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(), "rand");
        end

        doReset();
        applyStimulus(32'h00100093, 1, 32'h4, 0, 5'd0, 32'd0, "st_addi");
        applyStimulus(32'hFE628CE3, 1, 32'h8, 0, 5'd0, 32'd0, "st_beq");
        applyStimulus(32'h00100093, 1, 32'h0, 0, 5'd0, 32'd0, "st_addi2");
        applyStimulus(32'h00100093, 0, 32'h4, 0, 5'd0, 32'd0, "st_idle");
        checkOutput("stats.instr_cnt", instr_cnt, cntExp(32'd3));
        checkOutput("stats.redir_cnt", redir_cnt, cntExp(32'd1));

        applyStimulus(32'h00000073, 1, 32'h40, 0, 5'd0, 32'd0, "ecall");
        checkOutput("ecall.halted_const", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(randInstr(), 1'($urandom_range(0, 1)), 32'h40, 0, 5'd0, 32'd0, "halt");
        end
        checkOutput("halt.pcmux_const", {30'd0, bus.pcmux}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("halt.async_clear", {31'd0, halted}, 32'd0);
        doReset();
        applyStimulus(32'h00100093, 1, 32'h4, 0, 5'd0, 32'd0, "post_halt");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
